// File: rtl/timer_bus_master_pkg.sv
// Shared definitions for the interval-timer bus master: register map,
// control bit positions and FSM state encoding.
package timer_bus_master_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_H   = 3'd5;

  localparam int unsigned CTL_ITO_BIT   = 0;
  localparam int unsigned CTL_CONT_BIT  = 1;
  localparam int unsigned CTL_START_BIT = 2;
  localparam int unsigned CTL_STOP_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTL,
    ST_RUN,
    ST_ACK,
    ST_STOP_WR,
    ST_SNAP_WR,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_CAP
  } state_t;

endpackage

// File: rtl/timer_bus_master.sv
// Avalon-MM initiator that programs, services and snapshots the interval timer.
// Bus outputs are registered so that they line up with the state that owns them.
module timer_bus_master
  import timer_bus_master_pkg::*;
#(
  parameter int unsigned TICK_W   = 16,
  parameter logic [3:0]  CTL_RUN  = 4'h7,
  parameter logic [3:0]  CTL_STOP = 4'h8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic [WORD_W-1:0]   cfg_period,
  input  logic                cfg_stop,
  input  logic                snap_req,
  output logic                busy,
  output logic                running,
  output logic                tick,
  output logic [TICK_W-1:0]   tick_count,
  output logic                snap_valid,
  output logic [WORD_W-1:0]   snap_value,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write_n,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                irq
);

  state_t              state;
  logic [WORD_W-1:0]   period;

  // Each branch sets up the bus cycle and flags for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      period     <= '0;
      address    <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      busy       <= 1'b0;
      running    <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
      snap_valid <= 1'b0;
      snap_value <= '0;
    end else begin
      address    <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      tick       <= 1'b0;
      snap_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (cfg_start) begin
            period     <= cfg_period;
            address    <= ADDR_PERIOD_L;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            writedata  <= cfg_period[15:0];
            busy       <= 1'b1;
            state      <= ST_WR_PL;
          end
        end

        ST_WR_PL: begin
          address    <= ADDR_PERIOD_H;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          writedata  <= period[31:16];
          state      <= ST_WR_PH;
        end

        ST_WR_PH: begin
          address    <= ADDR_CONTROL;
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          writedata  <= 16'(CTL_RUN);
          tick_count <= '0;
          state      <= ST_WR_CTL;
        end

        ST_WR_CTL: begin
          busy    <= 1'b0;
          running <= 1'b1;
          state   <= ST_RUN;
        end

        // irq outranks stop, which outranks snapshot; losers are dropped.
        ST_RUN: begin
          busy <= 1'b0;
          if (irq) begin
            address    <= ADDR_STATUS;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            tick       <= 1'b1;
            tick_count <= tick_count + TICK_W'(1);
            busy       <= 1'b1;
            state      <= ST_ACK;
          end else if (cfg_stop) begin
            address    <= ADDR_CONTROL;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            writedata  <= 16'(CTL_STOP);
            busy       <= 1'b1;
            state      <= ST_STOP_WR;
          end else if (snap_req) begin
            address    <= ADDR_SNAP_L;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SNAP_WR;
          end
        end

        ST_ACK: begin
          busy  <= 1'b0;
          state <= ST_RUN;
        end

        ST_STOP_WR: begin
          busy    <= 1'b0;
          running <= 1'b0;
          state   <= ST_IDLE;
        end

        // Slave read data lags the address by one cycle.
        ST_SNAP_WR: begin
          address <= ADDR_SNAP_L;
          state   <= ST_SNAP_RL;
        end

        ST_SNAP_RL: begin
          address <= ADDR_SNAP_H;
          state   <= ST_SNAP_RH;
        end

        ST_SNAP_RH: begin
          snap_value[15:0] <= readdata;
          state            <= ST_SNAP_CAP;
        end

        ST_SNAP_CAP: begin
          snap_value[31:16] <= readdata;
          snap_valid        <= 1'b1;
          busy              <= 1'b0;
          state             <= ST_RUN;
        end

        default: begin
          busy    <= 1'b0;
          running <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/timer_bus_master.md
# timer_bus_master

Avalon-MM initiator that owns the system interval timer's register port from the fabric side. It programs the 32-bit period and control registers and starts the timer. It services the timer interrupt by clearing the status register, counts ticks, and on request captures and reads back the 32-bit counter snapshot. It sits between hardware control logic and the timer's 16-bit slave port, in place of the CPU.

## Interface
Parameters:
- TICK_W, 16, width of tick counter
- CTL_RUN, 4'h7, control word written at start (bits ITO|CONT|START)
- CTL_STOP, 4'h8, control word written at stop (bit STOP)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle request: program period, start timer
- cfg_period  in  32  timer load value, sampled when cfg_start is accepted
- cfg_stop  in  1  one-cycle request: stop timer
- snap_req  in  1  one-cycle request: capture and read counter snapshot
- busy  out  1  high whenever FSM not in IDLE or RUN
- running  out  1  high in RUN and while servicing from RUN
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since last start, wraps
- snap_valid  out  1  one-cycle pulse, snap_value updated
- snap_value  out  32  last read snapshot
- address  out  3  Avalon word address
- chipselect  out  1  Avalon chipselect
- write_n  out  1  Avalon write, active low
- writedata  out  16  Avalon write data
- readdata  in  16  Avalon read data, registered in slave, latency 1, no waitrequest
- irq  in  1  timer interrupt, level

## Operation
- Register map driven: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Write cycle: one clock with chipselect=1, write_n=0, address/writedata valid. Outside writes: chipselect=0, write_n=1, writedata=0.
- Read: the slave has no read strobe. Drive address with chipselect=0; readdata for that address is valid one cycle later.
- States and transitions:
  - IDLE: cfg_start -> WR_PL, latch cfg_period. cfg_stop and snap_req are ignored.
  - WR_PL: write addr 2 = period[15:0] -> WR_PH.
  - WR_PH: write addr 3 = period[31:16] -> WR_CTL.
  - WR_CTL: write addr 1 = CTL_RUN, clear tick_count -> RUN.
  - RUN: priority irq > cfg_stop > snap_req.
    - irq -> ACK.
    - cfg_stop -> STOP_WR.
    - snap_req -> SNAP_WR.
  - ACK: write addr 0 = 0, pulse tick, tick_count+1 mod 2^TICK_W -> RUN.
  - STOP_WR: write addr 1 = CTL_STOP -> IDLE.
  - SNAP_WR: write addr 4 = 0 -> SNAP_RL.
  - SNAP_RL: address 4, no write -> SNAP_RH.
  - SNAP_RH: address 5, capture readdata into snap_value[15:0] -> SNAP_CAP.
  - SNAP_CAP: capture readdata into snap_value[31:16], pulse snap_valid -> RUN.
- Requests arriving in non-accepting states are dropped, not queued. Callers use busy.
- A status write coinciding with a new slave timeout event loses that event. This is accepted: one tick is lost; tick_count counts serviced interrupts only.
- cfg_period=0 is passed through unchanged.

## Timing
- Reset values: address=0, chipselect=0, write_n=1, writedata=0, busy=0, running=0, tick=0, tick_count=0, snap_valid=0, snap_value=0; state IDLE.
- Reset asserted mid-sequence aborts it at the next edge. No further bus cycles are issued. Timer state is left as partially written.
- All outputs are registered; a request accepted at edge k produces its first bus write in cycle k+1.
- Start: 3 write cycles, RUN entered 3 cycles after acceptance.
- IRQ service: irq sampled high in RUN -> status write next cycle, tick pulse in that same cycle. irq must read low by the following RUN cycle, so no double count.
- Snapshot: 4 cycles from acceptance to snap_valid. Low half is the readdata sampled at the end of SNAP_RH.
- running: 1 from WR_CTL exit until STOP_WR exit.

## Structure
- Shared package: register address constants (ADDR_STATUS..ADDR_SNAP_H), control bit positions, state enum.
- Single module, no sub-module.
- Bench uses the existing timer slave as the responder.

## Test plan
- Reset, then cfg_start with cfg_period=32'h0000_0009 -> writes (2,0x0009), (3,0x0000), (1,0x0007) on consecutive cycles; running=1.
- Running as above -> timer interrupt every 10 clocks. Each irq gives one status write and one tick; after 5 timeouts tick_count=5, no double counts.
- Period 32'h0001_869F, snap_req 20 cycles after start -> snap_valid after 4 cycles, snap_value equals the slave counter value at the snap write.
- irq and cfg_stop asserted in the same RUN cycle -> ACK first, then the stop is dropped. A cfg_stop reissued when busy=0 -> (1,0x0008), state IDLE, running=0.
- Reset pulsed during WR_PH -> no WR_CTL write; all outputs at reset values next cycle.
- tick_count at 16'hFFFF, one more irq -> wraps to 0, tick pulses.
